// File: rtl/vlsu_mem_master.sv
// Strided vector load/store master: one element access per cycle on a single byte-addressed memory port.
// Optional misaligned-element trap is enabled by defining VLSU_MISALIGN_TRAP_EN.
module vlsu_mem_master #(
  parameter int ADDR_WIDTH = 10,
  parameter int VL_WIDTH   = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic                  reqStore,
  input  logic [1:0]            reqEew,
  input  logic [ADDR_WIDTH-1:0] reqBase,
  input  logic signed [31:0]    reqStride,
  input  logic [VL_WIDTH-1:0]   reqVl,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [2:0]            writeEnable,
  output logic [2:0]            readEnable,
  output logic [31:0]           writeData,
  input  logic [31:0]           readData,
  output logic [VL_WIDTH-1:0]   storeIdx,
  input  logic [31:0]           storeData,
  output logic                  wbValid,
  output logic [VL_WIDTH-1:0]   wbIdx,
  output logic [31:0]           wbData,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  function automatic logic [1:0] norm_eew(input logic [1:0] e);
    return (e == 2'b11) ? 2'b10 : e;
  endfunction

  function automatic logic [2:0] eew_mask(input logic [1:0] e);
    case (e)
      2'b00:   return 3'b001;
      2'b01:   return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  function automatic logic [31:0] eew_data(input logic [31:0] d, input logic [1:0] e);
    case (e)
      2'b00:   return {24'd0, d[7:0]};
      2'b01:   return {16'd0, d[15:0]};
      default: return d;
    endcase
  endfunction

`ifdef VLSU_MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [ADDR_WIDTH-1:0] a, input logic [1:0] e);
    return ((e == 2'b01) && a[0]) || ((e == 2'b10) && (a[1:0] != 2'b00));
  endfunction
`endif

  state_t                        state, state_nxt;
  logic                          req_store;
  logic [1:0]                    req_eew;
  logic signed [ADDR_WIDTH-1:0]  req_stride;
  logic [VL_WIDTH-1:0]           req_vl;
  logic [VL_WIDTH-1:0]           idx, idx_nxt;
  logic [ADDR_WIDTH-1:0]         addr_nxt, addr_step;
  logic [2:0]                    we_nxt, re_nxt;
  logic [31:0]                   wd_nxt, wbd_nxt;
  logic [VL_WIDTH-1:0]           wbi_nxt;
  logic                          wbv_nxt, done_nxt, err_nxt;
  logic                          accept, last_elem;
  logic [1:0]                    new_eew;
  logic                          unused_stride_hi;

  // Only the low ADDR_WIDTH stride bits affect an address taken modulo 2^ADDR_WIDTH.
  assign unused_stride_hi = ^reqStride[31:ADDR_WIDTH];

  assign reqReady  = (state == IDLE);
  assign accept    = (state == IDLE) && reqValid && !flush;
  assign new_eew   = norm_eew(reqEew);
  assign addr_step = addr + req_stride;
  assign last_elem = (idx == req_vl - 1'b1);

  always_ff @(posedge clk) begin
    if (accept) begin
      req_store  <= reqStore;
      req_eew    <= new_eew;
      req_stride <= reqStride[ADDR_WIDTH-1:0];
      req_vl     <= reqVl;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    addr_nxt  = addr;
    we_nxt    = 3'b000;
    re_nxt    = 3'b000;
    wd_nxt    = 32'd0;
    wbv_nxt   = 1'b0;
    wbi_nxt   = wbIdx;
    wbd_nxt   = wbData;
    done_nxt  = 1'b0;
    err_nxt   = err;
    storeIdx  = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          err_nxt = 1'b0;
          if (reqVl == '0) begin
            state_nxt = FIN;
            done_nxt  = 1'b1;
          end
`ifdef VLSU_MISALIGN_TRAP_EN
          else if (misaligned(reqBase, new_eew)) begin
            state_nxt = FIN;
            done_nxt  = 1'b1;
            err_nxt   = 1'b1;
          end
`endif
          else begin
            state_nxt = RUN;
            idx_nxt   = '0;
            addr_nxt  = reqBase;
            if (reqStore) begin
              we_nxt = eew_mask(new_eew);
              wd_nxt = eew_data(storeData, new_eew);
            end else begin
              re_nxt = eew_mask(new_eew);
            end
          end
        end
      end
      RUN: begin
        // Element idx is on the port; element idx+1 is being loaded into the output flops.
        storeIdx = idx + 1'b1;
        if (!req_store) begin
          wbv_nxt = 1'b1;
          wbi_nxt = idx;
          wbd_nxt = eew_data(readData, req_eew);
        end
        if (last_elem) begin
          state_nxt = FIN;
          done_nxt  = 1'b1;
        end
`ifdef VLSU_MISALIGN_TRAP_EN
        else if (misaligned(addr_step, req_eew)) begin
          state_nxt = FIN;
          done_nxt  = 1'b1;
          err_nxt   = 1'b1;
        end
`endif
        else begin
          idx_nxt  = idx + 1'b1;
          addr_nxt = addr_step;
          if (req_store) begin
            we_nxt = eew_mask(req_eew);
            wd_nxt = eew_data(storeData, req_eew);
          end else begin
            re_nxt = eew_mask(req_eew);
          end
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = IDLE;
      we_nxt    = 3'b000;
      re_nxt    = 3'b000;
      wbv_nxt   = 1'b0;
      done_nxt  = 1'b0;
      err_nxt   = err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      addr        <= '0;
      writeEnable <= 3'b000;
      readEnable  <= 3'b000;
      writeData   <= 32'd0;
      wbValid     <= 1'b0;
      wbIdx       <= '0;
      wbData      <= 32'd0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      addr        <= addr_nxt;
      writeEnable <= we_nxt;
      readEnable  <= re_nxt;
      writeData   <= wd_nxt;
      wbValid     <= wbv_nxt;
      wbIdx       <= wbi_nxt;
      wbData      <= wbd_nxt;
      done        <= done_nxt;
      err         <= err_nxt;
    end
  end

endmodule

// File: tb/tb_vlsu_mem_master.sv
// Randomized bench for vlsu_mem_master with a byte-array memory, a VRF table and a transaction-level reference.
module tb_vlsu_mem_master;
  localparam int AW = 10;
  localparam int VW = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              reqValid = 1'b0;
  logic              reqReady;
  logic              reqStore = 1'b0;
  logic [1:0]        reqEew = 2'b00;
  logic [AW-1:0]     reqBase = '0;
  logic signed [31:0] reqStride = '0;
  logic [VW-1:0]     reqVl = '0;
  logic              flush = 1'b0;
  logic [AW-1:0]     addr;
  logic [2:0]        writeEnable, readEnable;
  logic [31:0]       writeData, readData, storeData, wbData;
  logic [VW-1:0]     storeIdx, wbIdx;
  logic              wbValid, done, err;

  logic [7:0]  mem     [1024];
  logic [7:0]  ref_mem [1024];
  logic [31:0] vrf     [64];

  int   checks = 0;
  int   failures = 0;
  logic err_state = 1'b0;

  vlsu_mem_master #(.ADDR_WIDTH(AW), .VL_WIDTH(VW)) dut (
    .clk(clk), .rst_n(rst_n), .reqValid(reqValid), .reqReady(reqReady),
    .reqStore(reqStore), .reqEew(reqEew), .reqBase(reqBase), .reqStride(reqStride),
    .reqVl(reqVl), .flush(flush), .addr(addr), .writeEnable(writeEnable),
    .readEnable(readEnable), .writeData(writeData), .readData(readData),
    .storeIdx(storeIdx), .storeData(storeData), .wbValid(wbValid), .wbIdx(wbIdx),
    .wbData(wbData), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  assign readData  = {mem[addr + 10'd3], mem[addr + 10'd2], mem[addr + 10'd1], mem[addr]};
  assign storeData = vrf[storeIdx];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] elem_addr(input logic [AW-1:0] base,
                                              input logic signed [31:0] stride, input int k);
    logic [31:0] t;
    t = 32'(base) + 32'(k) * stride;
    return t[AW-1:0];
  endfunction

  function automatic logic [31:0] ref_word(input logic [AW-1:0] a, input int nb);
    logic [31:0] w;
    w = 32'd0;
    for (int j = 0; j < nb; j++) w[8*j +: 8] = ref_mem[a + 10'(j)];
    return w;
  endfunction

  function automatic bit misal(input logic [AW-1:0] a, input int nb);
    return (nb == 2 && a[0]) || (nb == 4 && a[1:0] != 2'b00);
  endfunction

  // Memory side effect of the current cycle, applied mid-cycle.
  task automatic mem_cycle();
    if (writeEnable[0]) mem[addr] = writeData[7:0];
    if (writeEnable[1]) mem[addr + 10'd1] = writeData[15:8];
    if (writeEnable[2]) begin
      mem[addr + 10'd2] = writeData[23:16];
      mem[addr + 10'd3] = writeData[31:24];
    end
  endtask

  task automatic preload_word(input logic [AW-1:0] a, input logic [31:0] w);
    for (int j = 0; j < 4; j++) begin
      mem[a + 10'(j)]     = w[8*j +: 8];
      ref_mem[a + 10'(j)] = w[8*j +: 8];
    end
  endtask

  task automatic idle_check();
    chk("idle_ready", 64'(reqReady), 64'd1);
    chk("idle_en", 64'({writeEnable, readEnable}), 64'd0);
    chk("idle_wbvalid", 64'(wbValid), 64'd0);
    chk("idle_done", 64'(done), 64'd0);
    chk("idle_sidx", 64'(storeIdx), 64'd0);
    chk("idle_err", 64'(err), 64'(err_state));
  endtask

  // Entered and left at 1 time unit after a rising edge with the DUT idle.
  task automatic run_txn(input bit st, input logic [1:0] eew, input logic [AW-1:0] base,
                         input logic signed [31:0] stride, input int vl, input int fl_in,
                         input bit dir_vrf);
    int nb, n, last, k, fl;
    logic [2:0]  m;
    logic [31:0] emask, wexp;
    logic [AW-1:0] a;
    bit trap, active, wbv;
    nb = (eew == 2'b00) ? 1 : (eew == 2'b01) ? 2 : 4;
    m = (nb == 1) ? 3'b001 : (nb == 2) ? 3'b011 : 3'b111;
    emask = (nb == 1) ? 32'h0000_00FF : (nb == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    n = vl;
    trap = 1'b0;
`ifdef VLSU_MISALIGN_TRAP_EN
    for (int i = 0; i < vl; i++) begin
      if (misal(elem_addr(base, stride, i), nb)) begin
        n = i;
        trap = 1'b1;
        break;
      end
    end
`endif
    fl = (fl_in >= 1 && fl_in <= n) ? fl_in : 0;
    for (int i = 0; i < 64; i++) vrf[i] = dir_vrf ? (32'hA5A5_A5A0 + 32'(i)) : $urandom;
    reqValid = 1'b1; reqStore = st; reqEew = eew; reqBase = base; reqStride = stride;
    reqVl = VW'(vl);
    @(negedge clk);
    idle_check();
    mem_cycle();
    @(posedge clk); #1;
    reqValid = 1'b0;
    last = (fl != 0) ? fl + 1 : n + 2;
    for (int c = 1; c < last; c++) begin
      flush = (c == fl);
      @(negedge clk);
      k = c - 1;
      active = (k < n);
      a = elem_addr(base, stride, k);
      chk("en", 64'({writeEnable, readEnable}),
          active ? (st ? 64'({m, 3'b000}) : 64'({3'b000, m})) : 64'd0);
      if (active) begin
        chk("addr", 64'(addr), 64'(a));
        if (st) begin
          wexp = vrf[k] & emask;
          chk("wdata", 64'(writeData), 64'(wexp));
          for (int j = 0; j < nb; j++) ref_mem[a + 10'(j)] = wexp[8*j +: 8];
        end
      end
      wbv = !st && c >= 2 && (c - 2) < n;
      chk("wbvalid", 64'(wbValid), 64'(wbv));
      if (wbv) begin
        chk("wbidx", 64'(wbIdx), 64'(c - 2));
        chk("wbdata", 64'(wbData), 64'(ref_word(elem_addr(base, stride, c - 2), nb)));
      end
      chk("done", 64'(done), 64'(c == n + 1));
      chk("ready", 64'(reqReady), 64'd0);
      chk("sidx", 64'(storeIdx), (c <= n) ? 64'(c) : 64'd0);
      chk("err", 64'(err), (c >= n + 1) ? 64'(trap) : 64'd0);
      mem_cycle();
      @(posedge clk); #1;
    end
    flush = 1'b0;
    err_state = trap && (fl == 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    for (int i = 0; i < 64; i++) vrf[i] = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(reqReady), 64'd1);
    chk("rst_outs", 64'({addr, writeEnable, readEnable, wbValid, done, err}), 64'd0);
    chk("rst_data", 64'({writeData, wbData}), 64'd0);
    chk("rst_idx", 64'({wbIdx, storeIdx}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    preload_word(10'h010, 32'h11);
    preload_word(10'h014, 32'h22);
    preload_word(10'h018, 32'h33);
    preload_word(10'h01C, 32'h44);
    run_txn(1'b0, 2'b10, 10'h010, 32'sd4, 4, 0, 1'b0);
    run_txn(1'b1, 2'b00, 10'h3FE, 32'sd1, 4, 0, 1'b1);
    run_txn(1'b0, 2'b01, 10'h008, -32'sd2, 3, 0, 1'b0);
    run_txn(1'b0, 2'b00, 10'h100, 32'sd1, 0, 0, 1'b0);
    run_txn(1'b1, 2'b10, 10'h200, 32'sd4, 8, 2, 1'b0);
    run_txn(1'b0, 2'b10, 10'h200, 32'sd4, 8, 0, 1'b0);
    run_txn(1'b0, 2'b10, 10'h004, 32'sd6, 3, 0, 1'b0);
    run_txn(1'b1, 2'b11, 10'h040, 32'sd4, 2, 0, 1'b0);

    for (int t = 0; t < 60; t++) begin
      logic [AW-1:0] b;
      logic signed [31:0] s;
      b = AW'($urandom);
      if ($urandom_range(1, 0) == 1) b[1:0] = 2'b00;
      s = ($urandom_range(3, 0) == 0) ? 32'($urandom) : 32'(int'($urandom_range(16, 0)) - 8);
      run_txn(1'($urandom), 2'($urandom), b, s, int'($urandom_range(32, 0)),
              ($urandom_range(4, 0) == 0) ? int'($urandom_range(32, 1)) : 0, 1'b0);
    end

    run_txn(1'b0, 2'b00, 10'h000, 32'sd1, 0, 0, 1'b0);
    for (int i = 0; i < 1024; i++) begin
      if (mem[i] !== ref_mem[i]) begin
        chk("mem_final", 64'(mem[i]), 64'(ref_mem[i]));
        break;
      end
    end
    chk("mem_sample", 64'({mem[10'h3FE], mem[10'h3FF]}), 64'({ref_mem[10'h3FE], ref_mem[10'h3FF]}));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vlsu_mem_master.md
Name: vlsu_mem_master

Overview:
- Initiator side of the team's byte-addressable data-memory port: addr, 3-bit write/read enable masks, 32-bit write and read data.
- Executes one strided vector load or store (vl elements, EEW 8/16/32) by issuing one element access per cycle on a single memory port.
- Returns load elements to the vector register file and fetches store elements from it.
- Sits between the vector issue stage and one port of the data memory.

Parameters:
- ADDR_WIDTH, 10, memory byte-address width; matches the memory's port.
- VL_WIDTH, 6, width of vl and element indices (vl max 32).

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- reqValid  input  1  request valid
- reqReady  output  1  block can accept a request
- reqStore  input  1  1=store, 0=load
- reqEew  input  2  00=8b, 01=16b, 10=32b; 11 is illegal and treated as 10
- reqBase  input  ADDR_WIDTH  first element byte address
- reqStride  input  32  signed byte stride
- reqVl  input  VL_WIDTH  element count
- flush  input  1  synchronous abort
- addr  output  ADDR_WIDTH  memory address
- writeEnable  output  3  memory write mask
- readEnable  output  3  memory read mask
- writeData  output  32  memory write data
- readData  input  32  memory read data; combinational, valid in the same cycle
- storeIdx  output  VL_WIDTH  element index requested from the VRF
- storeData  input  32  VRF data for storeIdx; combinational
- wbValid  output  1  load element valid
- wbIdx  output  VL_WIDTH  load element index
- wbData  output  32  load element, zero-extended
- done  output  1  one-cycle completion pulse
- err  output  1  misalignment error; see Optional Feature

Behaviour:
- Reset (async, rst_n=0): state IDLE. reqReady=1. addr, writeEnable, readEnable, writeData, wbValid, wbIdx, wbData, done, err, storeIdx all 0.
- All outputs except reqReady and storeIdx are registered. reqReady=1 only in IDLE.
- Enable mask by EEW: 8b -> 3'b001, 16b -> 3'b011, 32b -> 3'b111. A store drives writeEnable with the mask and readEnable=0. A load drives readEnable with the mask and writeEnable=0.
- States:
  - IDLE: on reqValid&reqReady, latch the request and set index i=0.
    - vl=0: go to FIN with no memory activity.
    - vl>0: go to RUN.
  - RUN: element i is presented on the memory port during the cycle after it is loaded into the output flops.
    - Element 0 appears in the cycle after accept. Element i appears in accept cycle + 1 + i.
    - addr(i) = (reqBase + i*reqStride) truncated to ADDR_WIDTH. Wrap-around is modulo 2^ADDR_WIDTH. A negative stride wraps the same way.
    - Use a running address accumulator, not a multiplier.
  - FIN (last element presented): enables drop to 0, done=1 for one cycle, return to IDLE. reqReady is 1 again in the following cycle.
- Store path:
  - storeIdx is combinational and equals the index being loaded into the output flops: 0 in the accept cycle, then i+1.
  - writeData <= storeData masked to EEW; upper bits are zeroed.
- Load path:
  - In the cycle element i is on the port, readData is sampled.
  - wbValid=1, wbIdx=i, wbData=readData masked to EEW in the following cycle.
  - The last wbValid coincides with done.
- flush: in any state, the next cycle has enables=0, wbValid=0, done=0, state IDLE. Any partially completed stores remain written. flush in IDLE is a no-op. flush wins over a simultaneous reqValid.
- Back-to-back: a new request may be accepted in the cycle after done. There is no overlap between requests.
- Element count and ordering: exactly vl memory accesses, in index order, with no bubbles.

Optional Feature:
- Macro: VLSU_MISALIGN_TRAP_EN.
- Defined:
  - Before presenting element i, check the alignment of addr(i): 16b requires addr[0]=0; 32b requires addr[1:0]=0.
  - On failure, no access is issued for element i or later. Go to FIN with done=1 and err=1 in the same cycle.
  - Elements already issued complete normally.
  - err clears with the next accepted request.
- Undefined:
  - err is tied to 0 and no check is made.
  - Misaligned accesses are issued as-is; the memory handles byte addressing.

Test Plan:
- Load, EEW=32, base=0x010, stride=4, vl=4, memory preloaded with words 0x11..0x44 -> readEnable=3'b111 at addr 0x010, 0x014, 0x018, 0x01C in cycles 1–4. wbIdx 0..3 with matching data in cycles 2–5. done in cycle 5.
- Store, EEW=8, base=0x3FE, stride=1, vl=4, storeData=0xA5A5A5A0+idx -> writeEnable=3'b001. addr 0x3FE, 0x3FF, 0x000, 0x001 (wrap). writeData bytes A0..A3 with upper bits 0.
- Load, EEW=16, stride=-2, base=0x008, vl=3 -> addresses 0x008, 0x006, 0x004. readEnable=3'b011. wbData upper 16 bits=0.
- vl=0 request -> no enables asserted. done one cycle after accept. reqReady back to 1 in the cycle after done.
- flush asserted in the 2nd RUN cycle of a vl=8 store -> exactly 2 writes occur. No done. Idle next cycle, and a new request is accepted.
- With VLSU_MISALIGN_TRAP_EN defined: EEW=32, base=0x004, stride=6, vl=3 -> element 0 issued at 0x004. Element 1 (0x00A) is not issued. done=1 and err=1 together.
